// File: rtl/mem_access_arbiter_pkg.sv
// Shared encodings and default widths for the RAM access arbiter.
package mem_ctrl_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 32;
    localparam int DEFAULT_ADDR_WIDTH  = 9;
    localparam int DEFAULT_WAIT_CYCLES = 1;
    // Wide enough for WAIT_CYCLES up to 15.
    localparam int CNT_WIDTH           = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bundle of both requester ports plus the RAM-side signals.
// Handshake: each req is a level held by the requester until its done pulse
// is sampled high; done is a single-cycle pulse and the matching rdata is
// valid from that cycle until the next read on the same port.
interface mem_access_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_done;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_done;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data_in;
    logic                  mem_write_enable;
    logic                  mem_read_enable;
    logic [DATA_WIDTH-1:0] mem_data_out;
    logic                  busy;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        output if_rdata, if_done, d_rdata, d_done,
        output mem_addr, mem_data_in, mem_write_enable, mem_read_enable, busy
    );

    // Requesters plus RAM side.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        input  if_rdata, if_done, d_rdata, d_done,
        input  mem_addr, mem_data_in, mem_write_enable, mem_read_enable, busy
    );
endinterface

// File: rtl/mem_access_arbiter_rr_arbiter2.sv
// Two-input round-robin pick: a lone request wins, a tie goes to the port
// that was not granted last.
module rr_arbiter2
    import mem_ctrl_pkg::*;
(
    input  logic   req_a,
    input  logic   req_b,
    input  grant_t last_grant,
    output logic   valid,
    output grant_t grant
);

    // Pure combinational choice; req_a is the fetch port, req_b the data port.
    always_comb begin
        valid = req_a | req_b;
        grant = GNT_FETCH;
        if (req_a && req_b) begin
            grant = (last_grant == GNT_FETCH) ? GNT_DATA : GNT_FETCH;
        end else if (req_b) begin
            grant = GNT_DATA;
        end
    end

endmodule

// File: rtl/mem_access_arbiter.sv
// Sequences fetch and load/store accesses onto the single-port RAM.
module mem_access_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_access_arbiter_if.slave  bus,
    output state_t               state_dbg
);

    state_t                 state;
    grant_t                 grant_q;
    grant_t                 last_grant;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic                   we_q;
    logic [DATA_WIDTH-1:0]  if_rdata_q;
    logic [DATA_WIDTH-1:0]  d_rdata_q;
    logic                   if_done_q;
    logic                   d_done_q;
    logic                   pick_valid;
    grant_t                 pick;

    rr_arbiter2 u_rr (
        .req_a      (bus.if_req),
        .req_b      (bus.d_req),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .grant      (pick)
    );

    // Access sequencer: grant in IDLE, hold enables in ACCESS, pulse done in DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            grant_q    <= GNT_FETCH;
            last_grant <= GNT_FETCH;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q    <= pick;
                        last_grant <= pick;
                        cnt        <= CNT_WIDTH'(WAIT_CYCLES - 1);
                        state      <= ACCESS;
                        if (pick == GNT_DATA) begin
                            addr_q  <= bus.d_addr;
                            wdata_q <= bus.d_wdata;
                            we_q    <= bus.d_we;
                        end else begin
                            // Fetch never writes; store data is left as-is.
                            addr_q  <= bus.if_addr;
                            we_q    <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (!we_q) begin
                            if (grant_q == GNT_FETCH) if_rdata_q <= bus.mem_data_out;
                            else                      d_rdata_q  <= bus.mem_data_out;
                        end
                        if (grant_q == GNT_FETCH) if_done_q <= 1'b1;
                        else                      d_done_q  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Enables come only from state and latched fields, so live port inputs
    // can never glitch the RAM mid-access.
    assign bus.mem_read_enable  = (state == ACCESS) && !we_q;
    assign bus.mem_write_enable = (state == ACCESS) &&  we_q;
    assign bus.mem_addr         = addr_q;
    assign bus.mem_data_in      = wdata_q;
    assign bus.if_rdata         = if_rdata_q;
    assign bus.d_rdata          = d_rdata_q;
    assign bus.if_done          = if_done_q;
    assign bus.d_done           = d_done_q;
    assign bus.busy             = (state != IDLE);
    assign state_dbg            = state;

endmodule
